// File: rtl/opb_regbank_pkg.sv
// Purpose: shared widths, FSM encoding and OPB bit-order / byte-enable helpers for the register bank.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package opb_regbank_pkg;

  localparam int OPB_DW   = 32;
  localparam int MAX_REGS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  // OPB numbers bit 0 as the MSB; these map between that and [31:0] order.
  function automatic logic [OPB_DW-1:0] opb_to_le(input logic [0:OPB_DW-1] d);
    logic [OPB_DW-1:0] r;
    r = '0;
    for (int i = 0; i < OPB_DW; i++) r[OPB_DW-1-i] = d[i];
    return r;
  endfunction

  function automatic logic [0:OPB_DW-1] le_to_opb(input logic [OPB_DW-1:0] d);
    logic [0:OPB_DW-1] r;
    r = '0;
    for (int i = 0; i < OPB_DW; i++) r[i] = d[OPB_DW-1-i];
    return r;
  endfunction

  // BE[0] covers register bits [31:24], BE[3] covers [7:0].
  function automatic logic [OPB_DW-1:0] be_mask(input logic [0:3] be);
    logic [OPB_DW-1:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[OPB_DW-1-8*b -: 8] = {8{be[b]}};
    return m;
  endfunction

endpackage

// File: rtl/opb_regbank_cell.sv
// Purpose: one PPC-writable 32-bit register with byte merge, self-clearing pulse bits and write strobe.
// Latency: value updates at the commit edge; strobe is high the following cycle.
// Backpressure: none; a write is taken whenever wr_en is high.
// Ports: clk/rst (sync, active high), wr_en + wdat + bmask (write), reg_q (contents), strobe (write pulse).
module opb_regbank_cell
  import opb_regbank_pkg::*;
#(
  parameter logic [OPB_DW-1:0] RESET_VAL  = '0,
  parameter logic [OPB_DW-1:0] PULSE_MASK = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [OPB_DW-1:0] wdat,
  input  logic [OPB_DW-1:0] bmask,
  output logic [OPB_DW-1:0] reg_q,
  output logic              strobe
);

  // pend_q remembers which pulse bits the last write set, so only those clear;
  // pulse bits that come from the reset value are left alone.
  logic [OPB_DW-1:0] pend_q;
  logic [OPB_DW-1:0] base;
  logic [OPB_DW-1:0] merged;

  assign base   = reg_q & ~pend_q;
  // A fresh write of 1 into a pending pulse bit wins over the clear.
  assign merged = (wdat & bmask) | (base & ~bmask);

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q  <= RESET_VAL;
      pend_q <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= wr_en;
      if (wr_en) begin
        reg_q  <= merged;
        pend_q <= wdat & bmask & PULSE_MASK;
      end else begin
        reg_q  <= base;
        pend_q <= '0;
      end
    end
  end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// Purpose: OPB slave exposing C_NUM_REGS 32-bit registers (RW control or RO status) to user logic.
// Latency: ack one cycle after a hit; transfers take 2 cycles, back-to-back every 2 cycles.
// Backpressure: never retries or errors; non-hit addresses are simply not acked.
// Ports: OPB slave (OPB_* in, Sl_* out), user_data_out/user_data_in register slots, user_wr_strobe per register.
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0]            C_BASEADDR   = 32'h0100_0200,
  parameter logic [31:0]            C_HIGHADDR   = 32'h0100_02FF,
  parameter int                     C_OPB_AWIDTH = 32,
  parameter int                     C_OPB_DWIDTH = 32,
  parameter                         C_FAMILY     = "virtex6",
  parameter int                     C_NUM_REGS   = 4,
  parameter logic [MAX_REGS-1:0]    C_RO_MASK    = '0,
  parameter logic [OPB_DW-1:0]      C_PULSE_MASK = '0,
  parameter logic [32*MAX_REGS-1:0] C_RESET_VAL  = '0
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0] user_data_out,
  input  logic [32*C_NUM_REGS-1:0] user_data_in,
  output logic [C_NUM_REGS-1:0]   user_wr_strobe
);

  localparam unused_family = C_FAMILY;

  state_t state_q, state_d;

  logic [OPB_DW-1:0] addr, off, wdat, bmask, rd_mux, rdat_q;
  logic [3:0]        idx;
  logic              hit, in_range, take;
  logic [C_NUM_REGS-1:0] wr_en, strobe;
  logic [OPB_DW-1:0] reg_q [C_NUM_REGS];
  logic              unused_ok;

  assign addr     = opb_to_le(OPB_ABus);
  assign wdat     = opb_to_le(OPB_DBus);
  assign bmask    = be_mask(OPB_BE);
  assign hit      = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign off      = addr - C_BASEADDR;
  assign idx      = off[5:2];
  assign in_range = (off[31:2] < 30'(C_NUM_REGS));

  // State register
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: ACK always lasts one cycle and never looks at the bus.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: commit enables for the IDLE->ACK edge; ack is the ACK state itself.
  always_comb begin
    take  = (state_q == IDLE) && hit;
    wr_en = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (take && !OPB_RNW && in_range && (idx == 4'(i)) && !C_RO_MASK[i]) wr_en[i] = 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (in_range && (idx == 4'(i)))
        rd_mux = C_RO_MASK[i] ? user_data_in[32*i +: 32] : reg_q[i];
    end
  end

  // Read data (including RO status) is captured at the commit edge.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst)            rdat_q <= '0;
    else if (take && OPB_RNW) rdat_q <= rd_mux;
    else                    rdat_q <= '0;
  end

  // A reset arriving during the ACK cycle suppresses the ack and strobe at once.
  assign Sl_xferAck     = (state_q == ACK) && !OPB_Rst;
  assign Sl_DBus        = le_to_opb(Sl_xferAck ? rdat_q : '0);
  assign user_wr_strobe = OPB_Rst ? '0 : strobe;
  assign Sl_errAck      = 1'b0;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_slot
    if (!C_RO_MASK[i]) begin : g_rw
      opb_regbank_cell #(
        .RESET_VAL  (C_RESET_VAL[32*i +: 32]),
        .PULSE_MASK (C_PULSE_MASK)
      ) u_cell (
        .clk    (OPB_Clk),
        .rst    (OPB_Rst),
        .wr_en  (wr_en[i]),
        .wdat   (wdat),
        .bmask  (bmask),
        .reg_q  (reg_q[i]),
        .strobe (strobe[i])
      );
      assign user_data_out[32*i +: 32] = reg_q[i];
    end else begin : g_ro
      assign reg_q[i]                  = '0;
      assign strobe[i]                 = 1'b0;
      assign user_data_out[32*i +: 32] = '0;
    end
  end

  // Low address bits, seqAddr and the status inputs of RW slots carry no meaning here.
  assign unused_ok = ^{OPB_seqAddr, off[1:0], wr_en, user_data_in};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
module tb_opb_register_bank_ppc2simulink;

  localparam logic [32*16-1:0] RV    = {{14{32'h0}}, 32'hDEADBEEF, 32'h0};
  localparam logic [15:0]      RO    = 16'h0008;
  localparam logic [31:0]      PULSE = 32'h0000_0001;
  localparam logic [31:0]      BASE  = 32'h0100_0200;

  logic          clk;
  logic          OPB_Rst;
  logic [0:31]   OPB_ABus;
  logic [0:3]    OPB_BE;
  logic [0:31]   OPB_DBus;
  logic          OPB_RNW, OPB_select, OPB_seqAddr;
  logic [0:31]   Sl_DBus;
  logic          Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [127:0]  user_data_out, user_data_in;
  logic [3:0]    user_wr_strobe;

  opb_register_bank_ppc2simulink #(
    .C_NUM_REGS   (4),
    .C_RO_MASK    (RO),
    .C_PULSE_MASK (PULSE),
    .C_RESET_VAL  (RV)
  ) dut (
    .OPB_Clk        (clk),
    .OPB_Rst        (OPB_Rst),
    .OPB_ABus       (OPB_ABus),
    .OPB_BE         (OPB_BE),
    .OPB_DBus       (OPB_DBus),
    .OPB_RNW        (OPB_RNW),
    .OPB_select     (OPB_select),
    .OPB_seqAddr    (OPB_seqAddr),
    .Sl_DBus        (Sl_DBus),
    .Sl_xferAck     (Sl_xferAck),
    .Sl_errAck      (Sl_errAck),
    .Sl_retry       (Sl_retry),
    .Sl_toutSup     (Sl_toutSup),
    .user_data_out  (user_data_out),
    .user_data_in   (user_data_in),
    .user_wr_strobe (user_wr_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: persistent contents of the three RW registers.
  logic [31:0] mreg [3];

  logic         t_ack;
  logic [31:0]  t_rd;
  logic [3:0]   t_stb, t_stb_after;
  logic [127:0] t_udo;
  int           t_lat;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_udo();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[32*i +: 32] = mreg[i];
    return r;
  endfunction

  function automatic logic [31:0] tb_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mreg[i] = RV[32*i +: 32];
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic xfer(input logic rnw, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d, input int budget);
    t_ack = 1'b0; t_rd = '0; t_stb = '0; t_stb_after = '0; t_udo = '0; t_lat = 0;
    OPB_ABus = a; OPB_BE = be; OPB_DBus = d; OPB_RNW = rnw; OPB_select = 1'b1;
    for (int c = 1; c <= budget && !t_ack; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (Sl_xferAck) begin
        t_ack = 1'b1; t_lat = c; t_rd = Sl_DBus; t_stb = user_wr_strobe; t_udo = user_data_out;
      end
    end
    OPB_select = 1'b0; OPB_RNW = 1'b1; OPB_DBus = '0; OPB_BE = '0;
    @(posedge clk);
    #1;
    t_stb_after = user_wr_strobe;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    OPB_Rst = 1'b1; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0;
    OPB_RNW = 1'b1; OPB_select = 1'b0; OPB_seqAddr = 1'b0; user_data_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    OPB_Rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ack", Sl_xferAck, 0);
    check("rst_dbus", Sl_DBus, 0);
    check("rst_strobe", user_wr_strobe, 0);
    check("rst_udo", user_data_out, exp_udo());
    check("tie_offs", {Sl_errAck, Sl_retry, Sl_toutSup}, 0);
    @(posedge clk);
    #1;

    // Reset value read-back
    xfer(1'b1, BASE + 32'h4, 4'hF, '0, 4);
    check("rd_reg1_ack", t_ack, 1);
    check("rd_reg1_lat", t_lat, 1);
    check("rd_reg1_data", t_rd, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      if (k != 1) begin
        xfer(1'b1, BASE + 32'(4*k), 4'hF, '0, 4);
        check("rd_reset_zero", t_rd, 0);
      end
    end

    // Byte-enabled write
    xfer(1'b0, BASE, 4'b1010, 32'h12345678, 4);
    check("wr_be_ack_lat", t_lat, 1);
    check("wr_be_strobe", t_stb, 4'b0001);
    check("wr_be_strobe_after", t_stb_after, 0);
    check("wr_be_val", user_data_out[31:0], 32'h12005600);
    mreg[0] = 32'h12005600;
    xfer(1'b1, BASE, 4'hF, '0, 4);
    check("wr_be_readback", t_rd, 32'h12005600);

    // Pulse bit on reg2
    xfer(1'b0, BASE + 32'h8, 4'hF, 32'h3, 4);
    check("pulse_ack_cycle", t_udo[95:64], 32'h3);
    check("pulse_strobe", t_stb, 4'b0100);
    check("pulse_after", user_data_out[95:64], 32'h2);
    mreg[2] = 32'h2;
    xfer(1'b1, BASE + 32'h8, 4'hF, '0, 4);
    check("pulse_readback", t_rd, 32'h2);

    // Read-only status slot
    user_data_in[127:96] = 32'hCAFEF00D;
    xfer(1'b1, BASE + 32'hC, 4'hF, '0, 4);
    check("ro_read", t_rd, 32'hCAFEF00D);
    xfer(1'b0, BASE + 32'hC, 4'hF, 32'h11111111, 4);
    check("ro_wr_ack", t_ack, 1);
    check("ro_wr_strobe", t_stb, 0);
    check("ro_wr_udo", user_data_out, exp_udo());
    xfer(1'b1, BASE + 32'hC, 4'hF, '0, 4);
    check("ro_read_again", t_rd, 32'hCAFEF00D);

    // Held select: ack lasts one cycle, never twice in a row; a still-held select
    // in the following IDLE cycle is a new transfer.
    pat = '0;
    OPB_ABus = BASE; OPB_RNW = 1'b1; OPB_BE = 4'hF; OPB_select = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pat[c] = Sl_xferAck;
      if (c < 3) @(posedge clk);
    end
    OPB_select = 1'b0;
    @(posedge clk);
    #1;
    check("held_select_acks", pat, 4'b1010);

    xfer(1'b1, BASE + 32'h40, 4'hF, '0, 4);
    check("oob_index_ack", t_ack, 1);
    check("oob_index_data", t_rd, 0);
    xfer(1'b1, 32'h0100_0300, 4'hF, '0, 4);
    check("miss_no_ack", t_ack, 0);

    // Reset during the ACK cycle of a write
    OPB_ABus = BASE; OPB_RNW = 1'b0; OPB_BE = 4'hF; OPB_DBus = 32'hFFFFFFFF; OPB_select = 1'b1;
    @(posedge clk);
    #1;
    OPB_Rst = 1'b1; OPB_select = 1'b0;
    @(negedge clk);
    check("rst_in_ack_ack", Sl_xferAck, 0);
    check("rst_in_ack_strobe", user_wr_strobe, 0);
    @(posedge clk);
    #1;
    OPB_Rst = 1'b0; OPB_RNW = 1'b1; OPB_DBus = '0;
    model_reset();
    check("rst_in_ack_udo", user_data_out, exp_udo());
    @(negedge clk);
    check("rst_in_ack_no_late_ack", Sl_xferAck, 0);
    @(posedge clk);
    #1;

    // Randomized transfers against the model
    for (int n = 0; n < 40; n++) begin
      int          k;
      logic        rnw;
      logic [3:0]  be;
      logic [31:0] d, m, merged, expv;
      k   = int'($urandom_range(0, 4));
      rnw = 1'($urandom_range(0, 1));
      be  = 4'($urandom);
      d   = $urandom;
      OPB_seqAddr = 1'($urandom_range(0, 1));
      user_data_in[127:96] = $urandom;
      xfer(rnw, BASE + 32'(4*k) + 32'($urandom_range(0, 3)), be, d, 4);
      check("rnd_ack", t_ack, 1);
      if (rnw) begin
        if (k == 3)     expv = user_data_in[127:96];
        else if (k < 3) expv = mreg[k];
        else            expv = '0;
        check("rnd_rd", t_rd, expv);
        check("rnd_rd_strobe", t_stb, 0);
      end else if (k < 3) begin
        m      = tb_mask(be);
        merged = (d & m) | (mreg[k] & ~m);
        check("rnd_wr_ack_val", t_udo[32*k +: 32], merged);
        check("rnd_wr_strobe", t_stb, 4'(1 << k));
        mreg[k] = merged & ~(d & m & PULSE);
      end else begin
        check("rnd_wr_ignored_strobe", t_stb, 0);
      end
      check("rnd_strobe_after", t_stb_after, 0);
      check("rnd_udo", user_data_out, exp_udo());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
